// File: rtl/decode_pkg.sv
// Shared types, opcode constants and funct-legality helpers for the ID stage.
package decode_pkg;

  localparam int unsigned XlenDefault = 64;

  // Encoding 0 is the reset / illegal value of the output slot.
  typedef enum logic [3:0] {
    OcIllegal = 4'd0,
    OcLui     = 4'd1,
    OcAuipc   = 4'd2,
    OcJal     = 4'd3,
    OcJalr    = 4'd4,
    OcBranch  = 4'd5,
    OcLoad    = 4'd6,
    OcStore   = 4'd7,
    OcOpImm   = 4'd8,
    OcOp      = 4'd9,
    OcOpImm32 = 4'd10,
    OcOp32    = 4'd11,
    OcFence   = 4'd12,
    OcSystem  = 4'd13,
    OcHalt    = 4'd14
  } opclass_e;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  typedef struct packed {
    opclass_e   opclass;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
    logic       halt;
  } dec_t;

  // Upper six bits of a shift-immediate: logical (000000) or arithmetic (010000).
  function automatic logic shamt_hi_ok(input logic [5:0] hi);
    return (hi == 6'b000000) || (hi == 6'b010000);
  endfunction

  // *W forms only exist as ADD/SUB, SLL, SRL/SRA.
  function automatic logic w_funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  function automatic logic r_funct7_ok(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == 7'b0000000) ||
           ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RISC-V immediate extraction, sign-extended from instr[31] to XLEN.
module rv_imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm32 = {instr[31:12], 12'b0};
      ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = {{(XLEN - 32){imm32[31]}}, imm32};

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with RV64I decode into a single registered output slot.
// DECODE_HALT_ZERO_EN: decode 32'h0 as HALT and lock the stage until reset.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_npc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_npc,
  output opclass_e        id_opclass,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic            id_illegal,
  output logic            id_halt
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_shift;

  assign opcode   = if_instr[6:0];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];
  assign is_shift = (funct3[1:0] == 2'b01);

  dec_t     dec;
  imm_fmt_e fmt;
  logic     legal;
  logic     use_rd, use_rs1, use_rs2, use_f3, use_f7;

  always_comb begin
    dec     = '0;
    fmt     = ImmNone;
    legal   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    case (opcode)
      OpcLui: begin
        dec.opclass = OcLui;
        fmt         = ImmU;
        use_rd      = 1'b1;
      end
      OpcAuipc: begin
        dec.opclass = OcAuipc;
        fmt         = ImmU;
        use_rd      = 1'b1;
      end
      OpcJal: begin
        dec.opclass = OcJal;
        fmt         = ImmJ;
        use_rd      = 1'b1;
      end
      OpcJalr: begin
        dec.opclass = OcJalr;
        fmt         = ImmI;
        {use_rd, use_rs1, use_f3} = 3'b111;
        legal       = (funct3 == 3'b000);
      end
      OpcBranch: begin
        dec.opclass = OcBranch;
        fmt         = ImmB;
        {use_rs1, use_rs2, use_f3} = 3'b111;
        legal       = (funct3[2:1] != 2'b01);
      end
      OpcLoad: begin
        dec.opclass = OcLoad;
        fmt         = ImmI;
        {use_rd, use_rs1, use_f3} = 3'b111;
        legal       = (funct3 != 3'b111);
      end
      OpcStore: begin
        dec.opclass = OcStore;
        fmt         = ImmS;
        {use_rs1, use_rs2, use_f3} = 3'b111;
        legal       = !funct3[2];
      end
      OpcOpImm: begin
        dec.opclass = OcOpImm;
        fmt         = ImmI;
        {use_rd, use_rs1, use_f3} = 3'b111;
        legal       = !is_shift || shamt_hi_ok(if_instr[31:26]);
      end
      OpcOpImm32: begin
        dec.opclass = OcOpImm32;
        fmt         = ImmI;
        {use_rd, use_rs1, use_f3} = 3'b111;
        // 32-bit shifts only have a 5-bit shamt, so instr[25] must be clear.
        legal       = w_funct3_ok(funct3) &&
                      (!is_shift || (shamt_hi_ok(if_instr[31:26]) && !if_instr[25]));
      end
      OpcOp: begin
        dec.opclass = OcOp;
        {use_rd, use_rs1, use_rs2, use_f3, use_f7} = 5'b11111;
        legal       = r_funct7_ok(funct7, funct3);
      end
      OpcOp32: begin
        dec.opclass = OcOp32;
        {use_rd, use_rs1, use_rs2, use_f3, use_f7} = 5'b11111;
        legal       = w_funct3_ok(funct3) && r_funct7_ok(funct7, funct3);
      end
      OpcMiscMem: begin
        dec.opclass = OcFence;
        fmt         = ImmI;
        {use_rd, use_rs1, use_f3} = 3'b111;
      end
      OpcSystem: begin
        dec.opclass = OcSystem;
        fmt         = ImmI;
        {use_rd, use_rs1, use_f3} = 3'b111;
      end
      default: legal = 1'b0;
    endcase

    if (use_rd)  dec.rd     = if_instr[11:7];
    if (use_rs1) dec.rs1    = if_instr[19:15];
    if (use_rs2) dec.rs2    = if_instr[24:20];
    if (use_f3)  dec.funct3 = funct3;
    if (use_f7)  dec.funct7 = funct7;

    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      fmt         = ImmNone;
    end

`ifdef DECODE_HALT_ZERO_EN
    if (if_instr == 32'h0000_0000) begin
      dec         = '0;
      dec.opclass = OcHalt;
      dec.halt    = 1'b1;
      fmt         = ImmNone;
    end
`endif
  end

  logic [XLEN-1:0] imm;

  rv_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (if_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  logic            halted;
  logic            accept;
  logic            valid_q, valid_d;
  dec_t            slot_q, slot_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;

  assign if_ready = (!valid_q || ex_ready) && !halted && !flush;
  assign accept   = if_valid && if_ready;

`ifdef DECODE_HALT_ZERO_EN
  logic halted_q;

  // Only reset leaves the halted state; flush deliberately does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else if (accept && dec.halt) begin
      halted_q <= 1'b1;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      slot_d  = dec;
      imm_d   = imm;
      pc_d    = if_pc;
      npc_d   = if_npc;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
    end
  end

  assign id_valid   = valid_q;
  assign id_pc      = pc_q;
  assign id_npc     = npc_q;
  assign id_opclass = slot_q.opclass;
  assign id_rd      = slot_q.rd;
  assign id_rs1     = slot_q.rs1;
  assign id_rs2     = slot_q.rs2;
  assign id_funct3  = slot_q.funct3;
  assign id_funct7  = slot_q.funct7;
  assign id_imm     = imm_q;
  assign id_illegal = slot_q.illegal;
  assign id_halt    = slot_q.halt;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a behavioural decode/handshake model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc, if_npc;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [63:0] id_pc, id_npc, id_imm;
  opclass_e    id_opclass;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        id_illegal, id_halt;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_npc     (if_npc),
    .if_ready   (if_ready),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_npc     (id_npc),
    .id_opclass (id_opclass),
    .id_rd      (id_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_funct3  (id_funct3),
    .id_funct7  (id_funct7),
    .id_imm     (id_imm),
    .id_illegal (id_illegal),
    .id_halt    (id_halt)
  );

  typedef struct {
    opclass_e    oc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
    logic        halt;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_valid, m_halted;
  exp_t        m_slot;
  logic [63:0] m_pc;
  logic [63:0] pc_ctr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA field rules.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t       e;
    longint     s;
    logic [6:0] op;
    logic [2:0] f3;
    logic [7:0] f3_mask;
    byte        fmt;
    logic       ok;
    s       = longint'($signed(ins));
    op      = ins[6:0];
    f3      = ins[14:12];
    f3_mask = 8'hFF;
    fmt     = "X";
    ok      = 1'b1;
    e       = '{oc: OcIllegal, rd: 0, rs1: 0, rs2: 0, f3: 0, f7: 0, imm: 0, ill: 0, halt: 0};
    case (op)
      7'b0110111: begin e.oc = OcLui;     fmt = "U"; end
      7'b0010111: begin e.oc = OcAuipc;   fmt = "U"; end
      7'b1101111: begin e.oc = OcJal;     fmt = "J"; end
      7'b1100111: begin e.oc = OcJalr;    fmt = "I"; f3_mask = 8'b0000_0001; end
      7'b1100011: begin e.oc = OcBranch;  fmt = "B"; f3_mask = 8'b1111_0011; end
      7'b0000011: begin e.oc = OcLoad;    fmt = "I"; f3_mask = 8'b0111_1111; end
      7'b0100011: begin e.oc = OcStore;   fmt = "S"; f3_mask = 8'b0000_1111; end
      7'b0010011: begin e.oc = OcOpImm;   fmt = "I"; end
      7'b0011011: begin e.oc = OcOpImm32; fmt = "I"; f3_mask = 8'b0010_0011; end
      7'b0110011: begin e.oc = OcOp;      fmt = "R"; end
      7'b0111011: begin e.oc = OcOp32;    fmt = "R"; f3_mask = 8'b0010_0011; end
      7'b0001111: begin e.oc = OcFence;   fmt = "I"; end
      7'b1110011: begin e.oc = OcSystem;  fmt = "I"; end
      default:    ok = 1'b0;
    endcase
    ok = ok && f3_mask[f3];
    if ((op == 7'b0010011 || op == 7'b0011011) && (f3 == 3'd1 || f3 == 3'd5)) begin
      ok = ok && (ins[31:26] == 6'd0 || ins[31:26] == 6'b010000);
      if (op == 7'b0011011) ok = ok && !ins[25];
    end
    if (fmt == "R")
      ok = ok && (ins[31:25] == 7'd0 || (ins[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    if (ok) begin
      if (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R") e.rd = ins[11:7];
      if (fmt == "I" || fmt == "S" || fmt == "B" || fmt == "R") begin
        e.rs1 = ins[19:15];
        e.f3  = f3;
      end
      if (fmt == "S" || fmt == "B" || fmt == "R") e.rs2 = ins[24:20];
      if (fmt == "R") e.f7 = ins[31:25];
      case (fmt)
        "I": e.imm = s >>> 20;
        "S": e.imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
        "B": e.imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) <<< 11) |
                     (longint'(ins[30:25]) <<< 5) | (longint'(ins[11:8]) <<< 1);
        "U": e.imm = (s >>> 12) <<< 12;
        "J": e.imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) <<< 12) |
                     (longint'(ins[20]) <<< 11) | (longint'(ins[30:21]) <<< 1);
        default: e.imm = 64'd0;
      endcase
    end else begin
      e.oc  = OcIllegal;
      e.ill = 1'b1;
    end
`ifdef DECODE_HALT_ZERO_EN
    if (ins == 32'd0)
      e = '{oc: OcHalt, rd: 0, rs1: 0, rs2: 0, f3: 0, f7: 0, imm: 0, ill: 0, halt: 1};
`endif
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0:  r[6:0] = 7'b0110111;
      1:  r[6:0] = 7'b0010111;
      2:  r[6:0] = 7'b1101111;
      3:  r[6:0] = 7'b1100111;
      4:  r[6:0] = 7'b1100011;
      5:  r[6:0] = 7'b0000011;
      6:  r[6:0] = 7'b0100011;
      7:  r[6:0] = 7'b0010011;
      8:  r[6:0] = 7'b0011011;
      9:  r[6:0] = 7'b0110011;
      10: r[6:0] = 7'b0111011;
      11: r[6:0] = 7'b0001111;
      12: r[6:0] = 7'b1110011;
      default: ;
    endcase
    // Bias the top bits towards the interesting funct7 / shamt values.
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 3))
        0:       r[31:25] = 7'h00;
        1:       r[31:25] = 7'h20;
        2:       r[31:25] = 7'h01;
        default: r[31:25] = 7'h21;
      endcase
    end
    if (r == 32'd0) r = 32'h0000_0013;
    return r;
  endfunction

  task automatic check_slot();
    check_val("opclass", 64'(id_opclass), 64'(m_slot.oc));
    check_val("rd", 64'(id_rd), 64'(m_slot.rd));
    check_val("rs1", 64'(id_rs1), 64'(m_slot.rs1));
    check_val("rs2", 64'(id_rs2), 64'(m_slot.rs2));
    check_val("funct3", 64'(id_funct3), 64'(m_slot.f3));
    check_val("funct7", 64'(id_funct7), 64'(m_slot.f7));
    check_val("imm", id_imm, m_slot.imm);
    check_val("illegal", 64'(id_illegal), 64'(m_slot.ill));
    check_val("halt", 64'(id_halt), 64'(m_slot.halt));
    check_val("pc", id_pc, m_pc);
    check_val("npc", id_npc, m_pc + 64'd4);
  endtask

  // One clock: drive, check at negedge, advance the model, return 1 time unit after posedge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic er, input logic fl);
    logic exp_rdy;
    if_valid = v;
    if_instr = ins;
    if_pc    = pc_ctr;
    if_npc   = pc_ctr + 64'd4;
    ex_ready = er;
    flush    = fl;
    @(negedge clk);
    exp_rdy = (!m_valid || er) && !m_halted && !fl;
    check_val("if_ready", 64'(if_ready), 64'(exp_rdy));
    check_val("id_valid", 64'(id_valid), 64'(m_valid));
    if (m_valid) check_slot();
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_rdy) begin
      m_slot  = ref_decode(ins);
      m_pc    = pc_ctr;
      m_valid = 1'b1;
      if (m_slot.halt) m_halted = 1'b1;
      pc_ctr  = pc_ctr + 64'd4;
    end else if (er) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    if_valid = 1'b0;
    if_instr = 32'd0;
    if_pc    = 64'd0;
    if_npc   = 64'd0;
    flush    = 1'b0;
    ex_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
  endtask

  initial begin
    pc_ctr = 64'h1000;
    reset_dut();

    check_val("rst_valid", 64'(id_valid), 64'd0);
    check_val("rst_ready", 64'(if_ready), 64'd1);
    check_val("rst_pc", id_pc, 64'd0);
    check_val("rst_npc", id_npc, 64'd0);
    check_val("rst_imm", id_imm, 64'd0);
    check_val("rst_opclass", 64'(id_opclass), 64'd0);
    check_val("rst_fields", 64'({id_rd, id_rs1, id_rs2, id_funct3, id_funct7}), 64'd0);
    check_val("rst_illegal", 64'(id_illegal), 64'd0);
    check_val("rst_halt", 64'(id_halt), 64'd0);

    cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0);  // addi x1,x0,5
    check_val("addi_valid", 64'(id_valid), 64'd1);
    check_val("addi_class", 64'(id_opclass), 64'(OcOpImm));
    check_val("addi_rd", 64'(id_rd), 64'd1);
    check_val("addi_rs1", 64'(id_rs1), 64'd0);
    check_val("addi_f3", 64'(id_funct3), 64'd0);
    check_val("addi_imm", id_imm, 64'h5);
    check_val("addi_pc", id_pc, 64'h1000);

    cyc(1'b1, 32'hFE20_8CE3, 1'b1, 1'b0);  // beq x1,x2,-8
    check_val("beq_class", 64'(id_opclass), 64'(OcBranch));
    check_val("beq_rs1", 64'(id_rs1), 64'd1);
    check_val("beq_rs2", 64'(id_rs2), 64'd2);
    check_val("beq_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFF8);

    cyc(1'b1, 32'h8000_02B7, 1'b1, 1'b0);  // lui x5,0x80000
    check_val("lui_class", 64'(id_opclass), 64'(OcLui));
    check_val("lui_rd", 64'(id_rd), 64'd5);
    check_val("lui_imm", id_imm, 64'hFFFF_FFFF_8000_0000);

    cyc(1'b1, 32'h0200_D093, 1'b1, 1'b0);  // srli x1,x1,32
    check_val("srli32_class", 64'(id_opclass), 64'(OcOpImm));
    check_val("srli32_ill", 64'(id_illegal), 64'd0);

    cyc(1'b1, 32'h8000_D093, 1'b1, 1'b0);
    check_val("badshift_class", 64'(id_opclass), 64'(OcIllegal));
    check_val("badshift_ill", 64'(id_illegal), 64'd1);

    cyc(1'b1, 32'h0000_0080, 1'b1, 1'b0);  // opcode 0000000
    check_val("opc00_ill", 64'(id_illegal), 64'd1);
    check_val("opc00_valid", 64'(id_valid), 64'd1);

    // Stream with execute stalled for three cycles mid-way.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h0000_0093 | (32'(i + 1) << 20) | (32'(i % 31 + 1) << 7),
          !(i >= 3 && i < 6), 1'b0);
    end

    // Flush with both an incoming and a held instruction.
    cyc(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    cyc(1'b1, 32'h0070_0113, 1'b1, 1'b1);
    check_val("flush_valid", 64'(id_valid), 64'd0);
    cyc(1'b1, 32'h0030_0193, 1'b1, 1'b0);  // addi x3,x0,3
    check_val("post_flush_valid", 64'(id_valid), 64'd1);
    check_val("post_flush_rd", 64'(id_rd), 64'd3);
    check_val("post_flush_imm", id_imm, 64'd3);

    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0);
    end
    cyc(1'b0, 32'h13, 1'b1, 1'b0);

`ifdef DECODE_HALT_ZERO_EN
    cyc(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    check_val("halt_flag", 64'(id_halt), 64'd1);
    check_val("halt_valid", 64'(id_valid), 64'd1);
    check_val("halt_class", 64'(id_opclass), 64'(OcHalt));
    check_val("halt_ready", 64'(if_ready), 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h0050_0093, 1'b1, i == 2);
    reset_dut();
    check_val("halt_rst_ready", 64'(if_ready), 64'd1);
    cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    check_val("halt_rst_class", 64'(id_opclass), 64'(OcOpImm));
`else
    cyc(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    check_val("zero_ill", 64'(id_illegal), 64'd1);
    check_val("zero_halt", 64'(id_halt), 64'd0);
    cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    check_val("zero_next_valid", 64'(id_valid), 64'd1);
    check_val("zero_next_class", 64'(id_opclass), 64'(OcOpImm));
`endif
    cyc(1'b0, 32'h13, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

IF/ID pipeline register and RV64I instruction decoder directly downstream of the fetch stage. Captures each fetched instruction word with its PC and next PC through a valid/ready handshake, decodes it into operation class, register indices, funct fields and a sign-extended 64-bit immediate, and holds the result in a registered output slot for the execute stage. Handles branch flush from the memory stage and back-pressure from execute.

## Interface
- XLEN, 64, datapath and PC width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_valid  in  1  fetch presents an instruction (fetch `data_ack`)
- if_instr  in  32  instruction word
- if_pc  in  XLEN  address of if_instr
- if_npc  in  XLEN  if_pc + 4
- if_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  taken branch / redirect; kill held and incoming instruction
- ex_ready  in  1  execute consumes id_* this cycle
- id_valid  out  1  id_* outputs hold a decoded instruction
- id_pc, id_npc  out  XLEN  captured PCs
- id_opclass  out  4  decode_pkg::opclass_e
- id_rd, id_rs1, id_rs2  out  5  register indices; 0 when unused by the format
- id_funct3  out  3; id_funct7  out  7
- id_imm  out  XLEN  sign-extended immediate; 0 for R-type
- id_illegal  out  1  unrecognised opcode / funct combination
- id_halt  out  1  halt instruction decoded (see Configuration)

## Operation
- Single output slot, registered. if_ready = (!id_valid || ex_ready) && !halted && !flush.
- Accept: if_valid && if_ready → slot loads decode(if_instr), if_pc, if_npc; id_valid=1.
- Consume without new accept: id_valid && ex_ready → id_valid=0.
- flush (highest priority after reset): id_valid=0, incoming instruction dropped, halted unchanged.
- Opclasses: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM_32, OP_32, FENCE, SYSTEM, HALT, ILLEGAL.
- Immediates: I `{instr[31:20]}`, S `{[31:25],[11:7]}`, B `{[31],[7],[30:25],[11:8],0}`, U `{[31:12],12'b0}`, J `{[31],[19:12],[20],[30:21],0}`; all sign-extended from bit 31 to XLEN.
- Shift-immediates (funct3 001/101): RV64 shamt instr[25:20]; instr[31:26] not 000000/010000 → ILLEGAL; *_32 forms require instr[25]=0.
- OP/OP_32: funct7 not 0000000/0100000 (0100000 only for ADD/SUB, SRL/SRA) → ILLEGAL.
- Opcode low bits ≠ 2'b11 → ILLEGAL. ILLEGAL still passes with id_valid=1, id_illegal=1; execute decides trap.

## Timing
- Latency 1 cycle: accept at edge N, id_valid and fields valid after N.
- Throughput 1/cycle when ex_ready held high.
- Stall: ex_ready=0 with id_valid=1 → all id_* stable, if_ready=0.
- Reset: id_valid=0, id_halt=0, halted=0, id_pc/id_npc/id_imm=0, id_opclass=ILLEGAL encoding 0, indices/funct=0, id_illegal=0.
- flush and if_valid same cycle → nothing captured; id_valid=0 next cycle.
- flush and ex_ready same cycle → slot cleared regardless.
- if_ready is combinational from state, ex_ready, flush; no path from if_valid.

## Configuration
- DECODE_HALT_ZERO_EN defined: instruction 32'h00000000 decodes as HALT, id_halt=1 with id_valid; sets halted, if_ready stays 0 until reset; halt slot drains normally on ex_ready; flush does not clear halted.
- Undefined: 32'h00000000 decodes as ILLEGAL (id_illegal=1); id_halt tied 0; no halted state.

## Structure
- decode_pkg: opclass_e enum, RV opcode localparams (7'b0110111 etc.), imm format enum, XLEN default.
- Sub-module rv_imm_gen: combinational, instr + format → XLEN immediate.
- decode_stage: handshake/flush/halt sequential logic, opcode/funct decode, output slot.

## Test plan
- 0x00500093 (addi x1,x0,5) → OP_IMM, rd=1, rs1=0, funct3=0, imm=64'h5, id_valid one cycle after accept.
- 0xFE208CE3 (beq x1,x2,-8) → BRANCH, rs1=1, rs2=2, imm=64'hFFFF_FFFF_FFFF_FFF8; 0x800002B7 (lui x5,0x80000) → imm=64'hFFFF_FFFF_8000_0000.
- Back-to-back stream, ex_ready low 3 cycles mid-stream → id_* frozen, if_ready=0, no instruction lost or duplicated.
- flush asserted with if_valid=1 and id_valid=1 → next cycle id_valid=0; following instruction decodes normally.
- 0x0200D093 (srli with funct6 000000 bit25=... shamt 32) → OP_IMM legal; 0x8000D093 → ILLEGAL; opcode 7'b0000000 low bits 00 → ILLEGAL.
- 32'h00000000: with DECODE_HALT_ZERO_EN → id_halt=1, if_ready stuck 0 until reset; without → id_illegal=1, stream continues.
